// File: rtl/dec_issue_ctrl_pkg.sv
// dec_issue_ctrl_pkg: shared types and constants for the decode issue controller
package dec_issue_ctrl_pkg;
  localparam int NB_ARCH_REG = 32;
  typedef enum logic [1:0] {IDLE, DRAIN, SERIAL} issue_state_t;
endpackage

// File: rtl/dec_issue_ctrl_if.sv
// dec_issue_ctrl_if: decode/issue handshake bundle; stall counters exist only with DEC_ISSUE_STAT_EN
interface dec_issue_ctrl_if #(parameter int CNT_W = 4);
  logic             dec_v_i;
  logic             dec_rs1_v_i;
  logic [4:0]       dec_rs1_adr_i;
  logic             dec_rs2_v_i;
  logic [4:0]       dec_rs2_adr_i;
  logic             dec_wbk_v_i;
  logic [4:0]       dec_wbk_adr_i;
  logic             dec_is_load_i;
  logic             dec_serial_i;
  logic             ld_wbk_v_i;
  logic [4:0]       ld_wbk_adr_i;
  logic             retire_v_i;
  logic             branch_v_q_i;
  logic             issue_o;
  logic             stall_o;
  logic             bubble_o;
  logic [CNT_W-1:0] inflight_o;
  logic             busy_o;
`ifdef DEC_ISSUE_STAT_EN
  logic [31:0]      stall_hz_cnt_o;
  logic [31:0]      stall_full_cnt_o;
  logic [31:0]      stall_ser_cnt_o;
`endif
  modport master (
    output dec_v_i, dec_rs1_v_i, dec_rs1_adr_i, dec_rs2_v_i, dec_rs2_adr_i, dec_wbk_v_i,
           dec_wbk_adr_i, dec_is_load_i, dec_serial_i, ld_wbk_v_i, ld_wbk_adr_i,
           retire_v_i, branch_v_q_i,
    input  issue_o, stall_o, bubble_o, inflight_o, busy_o
`ifdef DEC_ISSUE_STAT_EN
    , input stall_hz_cnt_o, stall_full_cnt_o, stall_ser_cnt_o
`endif
  );
  modport slave (
    input  dec_v_i, dec_rs1_v_i, dec_rs1_adr_i, dec_rs2_v_i, dec_rs2_adr_i, dec_wbk_v_i,
           dec_wbk_adr_i, dec_is_load_i, dec_serial_i, ld_wbk_v_i, ld_wbk_adr_i,
           retire_v_i, branch_v_q_i,
    output issue_o, stall_o, bubble_o, inflight_o, busy_o
`ifdef DEC_ISSUE_STAT_EN
    , output stall_hz_cnt_o, stall_full_cnt_o, stall_ser_cnt_o
`endif
  );
endinterface

// File: rtl/dec_issue_ctrl_reg_scoreboard.sv
// reg_scoreboard: pending-load bit per architectural register with load-writeback bypass on reads
module reg_scoreboard
  import dec_issue_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       set_v,
  input  logic [4:0] set_adr,
  input  logic       clr_v,
  input  logic [4:0] clr_adr,
  input  logic       sq_v,
  input  logic [4:0] sq_adr,
  input  logic [4:0] rd1_adr,
  input  logic [4:0] rd2_adr,
  input  logic [4:0] waw_adr,
  output logic       rd1_p,
  output logic       rd2_p,
  output logic       waw_p
);
  logic [NB_ARCH_REG-1:0] pending_q, set_m, clr_m;
  assign set_m = set_v ? NB_ARCH_REG'(1) << set_adr : '0;
  assign clr_m = (clr_v ? NB_ARCH_REG'(1) << clr_adr : '0) | (sq_v ? NB_ARCH_REG'(1) << sq_adr : '0);
  // set is ORed after the clear so it wins; bit 0 is forced low so x0 never blocks
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pending_q <= '0;
    else pending_q <= ((pending_q & ~clr_m) | set_m) & ~NB_ARCH_REG'(1);
  assign rd1_p = pending_q[rd1_adr] & ~(clr_v && clr_adr == rd1_adr);
  assign rd2_p = pending_q[rd2_adr] & ~(clr_v && clr_adr == rd2_adr);
  assign waw_p = pending_q[waw_adr] & ~(clr_v && clr_adr == waw_adr);
endmodule

// File: rtl/dec_issue_ctrl.sv
// dec_issue_ctrl: dec0->dec1 issue/stall/bubble decision with load scoreboard, in-flight bound and serialisation
// Optional stall statistics counters are built when DEC_ISSUE_STAT_EN is defined.
module dec_issue_ctrl
  import dec_issue_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 4
) (
  input logic             clk,
  input logic             reset_n,
  dec_issue_ctrl_if.slave bus
);
  issue_state_t     state_q, state_d;
  logic [CNT_W-1:0] inflight_q;
  logic             last_issue_q, last_ld_q, last_ser_q;
  logic [4:0]       last_adr_q;
  logic             rs1_p, rs2_p, waw_p, hazard, full, drain_ok, permit, issue, squash, ld_issue;
  reg_scoreboard u_sb (
    .clk(clk), .reset_n(reset_n),
    .set_v(ld_issue), .set_adr(bus.dec_wbk_adr_i),
    .clr_v(bus.ld_wbk_v_i), .clr_adr(bus.ld_wbk_adr_i),
    .sq_v(squash & last_ld_q), .sq_adr(last_adr_q),
    .rd1_adr(bus.dec_rs1_adr_i), .rd2_adr(bus.dec_rs2_adr_i), .waw_adr(bus.dec_wbk_adr_i),
    .rd1_p(rs1_p), .rd2_p(rs2_p), .waw_p(waw_p)
  );
  always_comb begin
    hazard   = (bus.dec_rs1_v_i & rs1_p) | (bus.dec_rs2_v_i & rs2_p) | (bus.dec_wbk_v_i & waw_p);
    full     = (inflight_q == CNT_W'(MAX_INFLIGHT)) & ~bus.retire_v_i;
    drain_ok = (inflight_q == '0) | ((inflight_q == CNT_W'(1)) & bus.retire_v_i);
    permit   = (state_q == IDLE) ? (~bus.dec_serial_i | drain_ok) : (state_q == DRAIN) & drain_ok;
    issue    = bus.dec_v_i & ~bus.branch_v_q_i & ~hazard & ~full & permit;
    ld_issue = issue & bus.dec_is_load_i & bus.dec_wbk_v_i & (bus.dec_wbk_adr_i != '0);
    squash   = bus.branch_v_q_i & last_issue_q;
    // a blocked serial instruction only waits in DRAIN when older work is still in flight
    state_d  = (state_q == IDLE) ?
                 ((bus.dec_v_i & ~bus.branch_v_q_i & bus.dec_serial_i) ? (issue ? SERIAL : drain_ok ? IDLE : DRAIN) : IDLE) :
               (state_q == DRAIN) ? (bus.branch_v_q_i ? IDLE : issue ? SERIAL : DRAIN) :
               (bus.retire_v_i | (squash & last_ser_q)) ? IDLE : SERIAL;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q      <= IDLE;
      inflight_q   <= '0;
      last_issue_q <= 1'b0;
      last_ld_q    <= 1'b0;
      last_ser_q   <= 1'b0;
      last_adr_q   <= '0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_q + CNT_W'(issue) - CNT_W'(bus.retire_v_i) - CNT_W'(squash);
      last_issue_q <= issue;
      last_ld_q    <= ld_issue;
      last_ser_q   <= issue & bus.dec_serial_i;
      last_adr_q   <= bus.dec_wbk_adr_i;
    end
  assert property (@(posedge clk) disable iff (!reset_n)
    {1'b0, inflight_q} + {CNT_W'(0), issue} >= {CNT_W'(0), bus.retire_v_i} + {CNT_W'(0), squash});
  assign bus.issue_o    = issue;
  assign bus.stall_o    = bus.dec_v_i & ~issue & ~bus.branch_v_q_i;
  assign bus.bubble_o   = ~issue;
  assign bus.inflight_o = inflight_q;
  assign bus.busy_o     = (state_q != IDLE) | (inflight_q != '0);
`ifdef DEC_ISSUE_STAT_EN
  logic [31:0] hz_q, full_q, ser_q;
  // one cause per stall cycle: serial beats hazard beats full
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hz_q   <= '0;
      full_q <= '0;
      ser_q  <= '0;
    end else begin
      if (bus.stall_o & ~permit & ~&ser_q) ser_q <= ser_q + 32'd1;
      if (bus.stall_o & permit & hazard & ~&hz_q) hz_q <= hz_q + 32'd1;
      if (bus.stall_o & permit & ~hazard & full & ~&full_q) full_q <= full_q + 32'd1;
    end
  assign bus.stall_hz_cnt_o   = hz_q;
  assign bus.stall_full_cnt_o = full_q;
  assign bus.stall_ser_cnt_o  = ser_q;
`endif
endmodule

// File: tb/tb_dec_issue_ctrl.sv
// tb_dec_issue_ctrl: directed stimulus with queued expectations checked by a negedge monitor
module tb_dec_issue_ctrl;
  import dec_issue_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  dec_issue_ctrl_if #(.CNT_W(4)) bus();
  dec_issue_ctrl #(.MAX_INFLIGHT(4), .CNT_W(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  typedef struct {
    int           id;
    logic         iss, stl, bub;
    logic [3:0]   infl;
    logic         chk;
    logic [31:0]  pend;
    issue_state_t st;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, id = 0;
  task automatic cmp(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step%0d got=%0h exp=%0h", nm, n, act, exp);
    end
  endtask
  always @(negedge clk) if (q.size() != 0) begin
    exp_t e;
    e = q.pop_front();
    cmp("issue", e.id, 32'(bus.issue_o), 32'(e.iss));
    cmp("stall", e.id, 32'(bus.stall_o), 32'(e.stl));
    cmp("bubble", e.id, 32'(bus.bubble_o), 32'(e.bub));
    cmp("inflight", e.id, 32'(bus.inflight_o), 32'(e.infl));
    if (e.chk) begin
      cmp("pending", e.id, dut.u_sb.pending_q, e.pend);
      cmp("state", e.id, 32'(dut.state_q), 32'(e.st));
    end
  end
  task automatic step(input logic i, input logic s, input logic b, input logic [3:0] n,
                      input logic c = 1'b0, input logic [31:0] p = '0, input issue_state_t st = IDLE);
    q.push_back('{id, i, s, b, n, c, p, st});
    id++;
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    bus.dec_v_i = 0; bus.dec_rs1_v_i = 0; bus.dec_rs1_adr_i = 0; bus.dec_rs2_v_i = 0;
    bus.dec_rs2_adr_i = 0; bus.dec_wbk_v_i = 0; bus.dec_wbk_adr_i = 0; bus.dec_is_load_i = 0;
    bus.dec_serial_i = 0; bus.ld_wbk_v_i = 0; bus.ld_wbk_adr_i = 0; bus.retire_v_i = 0;
    bus.branch_v_q_i = 0;
  endtask
  task automatic ins(input logic r1v, input logic [4:0] r1, input logic r2v, input logic [4:0] r2,
                     input logic wv, input logic [4:0] rd, input logic ld, input logic ser);
    clr();
    bus.dec_v_i = 1; bus.dec_rs1_v_i = r1v; bus.dec_rs1_adr_i = r1; bus.dec_rs2_v_i = r2v;
    bus.dec_rs2_adr_i = r2; bus.dec_wbk_v_i = wv; bus.dec_wbk_adr_i = rd;
    bus.dec_is_load_i = ld; bus.dec_serial_i = ser;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog step%0d got=timeout exp=finish", id);
    $fatal(1, "watchdog");
  end
  initial begin
    clr();
    @(posedge clk);
    #1;
    step(0, 0, 1, 0, 1, 0, IDLE);
    step(0, 0, 1, 0, 1, 0, IDLE);
    reset_n = 1;
    step(0, 0, 1, 0, 1, 0, IDLE);
    // load x5 then dependent add; writeback arrives in the add's issue cycle
    ins(1, 1, 0, 0, 1, 5, 1, 0); step(1, 0, 0, 0, 1, 0, IDLE);
    ins(1, 5, 1, 1, 1, 6, 0, 0); step(0, 1, 1, 1, 1, 32'h20, IDLE);
    step(0, 1, 1, 1, 1, 32'h20, IDLE);
    bus.ld_wbk_v_i = 1; bus.ld_wbk_adr_i = 5; bus.retire_v_i = 1;
    step(1, 0, 0, 1, 1, 32'h20, IDLE);
    clr(); bus.retire_v_i = 1; step(0, 0, 1, 1, 1, 0, IDLE);
    clr(); step(0, 0, 1, 0);
    // in-flight limit
    ins(1, 11, 1, 12, 1, 10, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 4'(k));
    step(0, 1, 1, 4);
    bus.retire_v_i = 1; step(1, 0, 0, 4);
    clr(); step(0, 0, 1, 4);
    bus.retire_v_i = 1;
    for (int k = 0; k < 4; k++) step(0, 0, 1, 4'(4 - k));
    clr(); step(0, 0, 1, 0);
    // serialising CSR write behind three in-flight instructions
    ins(1, 11, 1, 12, 1, 10, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 4'(k));
    ins(1, 1, 0, 0, 0, 0, 0, 1); step(0, 1, 1, 3, 1, 0, IDLE);
    bus.retire_v_i = 1;
    step(0, 1, 1, 3, 1, 0, DRAIN);
    step(0, 1, 1, 2, 1, 0, DRAIN);
    step(1, 0, 0, 1, 1, 0, DRAIN);
    ins(1, 11, 1, 12, 1, 10, 0, 0); step(0, 1, 1, 1, 1, 0, SERIAL);
    bus.retire_v_i = 1; step(0, 1, 1, 1, 1, 0, SERIAL);
    bus.retire_v_i = 0; step(1, 0, 0, 0, 1, 0, IDLE);
    clr(); bus.retire_v_i = 1; step(0, 0, 1, 1);
    clr(); step(0, 0, 1, 0);
    // flush squashes load x7, older load x8 keeps its bit
    ins(1, 2, 0, 0, 1, 8, 1, 0); step(1, 0, 0, 0, 1, 0, IDLE);
    ins(1, 2, 0, 0, 1, 7, 1, 0); step(1, 0, 0, 1, 1, 32'h100, IDLE);
    ins(1, 3, 1, 4, 1, 9, 0, 0); bus.branch_v_q_i = 1; step(0, 0, 1, 2, 1, 32'h180, IDLE);
    clr(); step(0, 0, 1, 1, 1, 32'h100, IDLE);
    bus.ld_wbk_v_i = 1; bus.ld_wbk_adr_i = 8; bus.retire_v_i = 1; step(0, 0, 1, 1, 1, 32'h100, IDLE);
    clr(); step(0, 0, 1, 0, 1, 0, IDLE);
    // load to x0 never becomes pending
    ins(1, 1, 0, 0, 1, 0, 1, 0); step(1, 0, 0, 0, 1, 0, IDLE);
    ins(1, 0, 1, 0, 1, 9, 0, 0); step(1, 0, 0, 1, 1, 0, IDLE);
    clr(); bus.retire_v_i = 1; step(0, 0, 1, 2); step(0, 0, 1, 1);
    clr(); step(0, 0, 1, 0, 1, 0, IDLE);
    // asynchronous reset while SERIAL with pending x3
    ins(1, 1, 0, 0, 1, 3, 1, 0); step(1, 0, 0, 0, 1, 0, IDLE);
    ins(1, 1, 0, 0, 0, 0, 0, 1); bus.retire_v_i = 1; step(1, 0, 0, 1, 1, 32'h8, IDLE);
    clr(); step(0, 0, 1, 1, 1, 32'h8, SERIAL);
    reset_n = 0; step(0, 0, 1, 0, 1, 0, IDLE);
    reset_n = 1; step(0, 0, 1, 0, 1, 0, IDLE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
